// File: rtl/seq_generator.sv
// seq_generator -- serial pattern generator feeding a sequence detector.
//
// A request (pat_valid & pat_ready) latches the pattern, its length and a
// repetition count. The low pat_len bits of the pattern are then shifted out
// MSB-first on x, one bit per cycle, starting the cycle after acceptance.
// done pulses for the first idle cycle after a transmission; pat_ready is
// high in that cycle, so back-to-back requests leave exactly one idle cycle.
//
// Parameters:
//   PAT_W  pattern register width (2..15)
//   LEN_W  width of pat_len and rep_cnt
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   pat_valid  request present
//   pat_ready  request can be accepted (high in IDLE)
//   pat_data   pattern; only the low effective-length bits are sent
//   pat_len    bits to send; 0 or anything above PAT_W means PAT_W
//   rep_cnt    extra repetitions of the pattern
//   x          serial output bit (0 when not valid)
//   x_valid    x carries a pattern bit
//   busy       transmission in progress
//   done       one-cycle end-of-transmission pulse
//
// Build option:
//   SEQ_GEN_REPEAT_EN  when defined, rep_cnt is honoured (pattern is sent
//                      rep_cnt+1 times back to back). When undefined,
//                      rep_cnt is ignored and each request sends once.
//
// State table:
//   state    | meaning
//   ST_IDLE  | waiting for a request; pat_ready=1, done echoes done_q
//   ST_SHIFT | sending pattern bits, one per cycle, MSB of the field first

module seq_generator #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pat_valid,
    output logic             pat_ready,
    input  logic [PAT_W-1:0] pat_data,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [LEN_W-1:0] rep_cnt,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    // PAT_W never exceeds 15, so 4 bits hold any effective length or index.
    localparam int IDX_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] eff_len;
    logic             accept;
    logic             wrap;
    logic             rep_left;

    always_comb begin : eff_len_calc
        if ((pat_len == '0) || (32'(pat_len) > PAT_W)) begin
            eff_len = IDX_W'(PAT_W);
        end else begin
            eff_len = IDX_W'(pat_len);
        end
    end

`ifdef SEQ_GEN_REPEAT_EN
    logic [LEN_W-1:0] rep_q, rep_d;

    // Counts down to zero and then stops, so all-ones gives 2^LEN_W sends.
    assign rep_left = (rep_q != '0);

    always_comb begin : rep_comb
        rep_d = rep_q;
        if (accept) begin
            rep_d = rep_cnt;
        end else if (wrap) begin
            rep_d = rep_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : rep_reg
        if (!rst_n) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    logic unused_rep;

    assign rep_left   = 1'b0;
    assign unused_rep = ^rep_cnt;
`endif

    always_comb begin : fsm_comb
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        accept    = 1'b0;
        wrap      = 1'b0;
        pat_ready = 1'b0;
        busy      = 1'b0;
        x_valid   = 1'b0;
        x         = 1'b0;
        done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pat_ready = 1'b1;
                done      = done_q;
                if (pat_valid) begin
                    accept  = 1'b1;
                    state_d = ST_SHIFT;
                    pat_d   = pat_data;
                    len_d   = eff_len;
                    idx_d   = eff_len - IDX_W'(1);
                end
            end
            ST_SHIFT: begin
                busy    = 1'b1;
                x_valid = 1'b1;
                // Mask-and-reduce selects bit idx_q without a narrow index.
                x       = |(pat_q & (PAT_W'(1) << idx_q));
                if (idx_q == '0) begin
                    if (rep_left) begin
                        wrap  = 1'b1;
                        idx_d = len_q - IDX_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : fsm_reg
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

endmodule
